// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding,
// register-file constants and the MULT decode constants.
package hazard_stall_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO   = 5'd0;

    // MULT is R-type: SPECIAL opcode with funct 0x18.
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    localparam int unsigned CYC_W = 6;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for hazard_stall_ctrl: stage register fields in,
// register enables/flush/bubble controls and status out.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_is_mul;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_mispredict;
    logic             mul_done;

    logic             pc_write;
    logic             pc_redirect;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_hold;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             mul_start;
    logic             mul_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_is_mul,
               ex_mem_read, ex_rt, ex_mispredict, mul_done,
        input  pc_write, pc_redirect, ifid_write, ifid_flush, idex_hold,
               idex_bubble, exmem_bubble, mul_start, mul_timeout, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_is_mul,
               ex_mem_read, ex_rt, ex_mispredict, mul_done,
        output pc_write, pc_redirect, ifid_write, ifid_flush, idex_hold,
               idex_bubble, exmem_bubble, mul_start, mul_timeout, stall_count
    );

endinterface

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds a source
// operand of the instruction in ID.
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    // $zero never carries a real dependency.
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && id_valid &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline control for the 5-stage core: PC/IF/ID enables, flushes, ID/EX and
// EX/MEM bubbles, and front-end freeze while the Booth multiplier runs.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MUL_TIMEOUT = 40,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_ctrl_if.slave  bus
);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MUL_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic               mul_start_q, mul_start_d;
    logic               mul_timeout_q, mul_timeout_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic load_use;
    logic done_seen;
    logic pc_write, pc_redirect, ifid_write, ifid_flush;
    logic idex_hold, idex_bubble, exmem_bubble;

    hazard_detect u_hazard_detect (
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .load_use    (load_use)
    );

    // mul_done during the start-pulse cycle belongs to no multiply.
    assign done_seen = bus.mul_done && !mul_start_q;

    always_comb begin
        state_d       = state_q;
        cyc_cnt_d     = cyc_cnt_q;
        mul_start_d   = 1'b0;
        mul_timeout_d = mul_timeout_q;
        pc_write      = 1'b0;
        pc_redirect   = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_hold     = 1'b0;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;

        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.ex_mispredict) begin
                        pc_write    = 1'b1;
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        if (bus.id_valid && bus.id_is_mul) begin
                            state_d     = ST_MUL_BUSY;
                            mul_start_d = 1'b1;
                            cyc_cnt_d   = '0;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                    if (done_seen || (cyc_cnt_q == CYC_LAST)) begin
                        // Exit cycle: MULT moves on to MEM, front end still frozen.
                        state_d = ST_RUN;
                        if (!done_seen) mul_timeout_d = 1'b1;
                    end else begin
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cyc_cnt_q     <= '0;
            mul_start_q   <= 1'b0;
            mul_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cyc_cnt_q     <= cyc_cnt_d;
            mul_start_q   <= mul_start_d;
            mul_timeout_q <= mul_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.pc_redirect  = pc_redirect;
    assign bus.ifid_write   = ifid_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_hold    = idex_hold;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.exmem_bubble = exmem_bubble;
    assign bus.mul_start    = mul_start_q;
    assign bus.mul_timeout  = mul_timeout_q;
    assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes model expectations,
// a negedge monitor pops and compares. A 4-bit-counter copy checks saturation.
module tb_hazard_stall_ctrl;

    localparam int TO = 40;

    typedef struct {
        logic [8:0]  ctl;
        logic [15:0] sc;
        logic [3:0]  sc4;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(16)) bus16 ();
    hazard_stall_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.id_valid      = bus16.id_valid;
    assign bus4.id_rs         = bus16.id_rs;
    assign bus4.id_rt         = bus16.id_rt;
    assign bus4.id_uses_rt    = bus16.id_uses_rt;
    assign bus4.id_is_mul     = bus16.id_is_mul;
    assign bus4.ex_mem_read   = bus16.ex_mem_read;
    assign bus4.ex_rt         = bus16.ex_rt;
    assign bus4.ex_mispredict = bus16.ex_mispredict;
    assign bus4.mul_done      = bus16.mul_done;

    hazard_stall_ctrl #(.MUL_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    hazard_stall_ctrl #(.MUL_TIMEOUT(TO), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    int   cyc_no = 0;

    // Reference state: which cycle of a multiply is in EX (0 = none),
    // timeout flag, and unsaturated count of frozen-PC cycles.
    int          m_age = 0;
    bit          m_to = 1'b0;
    int unsigned m_stalls = 0;

    task automatic step(input bit rst, input bit vld, input logic [4:0] rs,
                        input logic [4:0] rt, input bit uses_rt, input bit is_mul,
                        input bit mem_rd, input logic [4:0] ert, input bit mp,
                        input bit done);
        exp_t e;
        bit pw, pr, iw, ifl, ih, ib, eb, lu, fin, by_done;
        @(posedge clk);
        #1;
        rst_n               = rst;
        bus16.id_valid      = vld;
        bus16.id_rs         = rs;
        bus16.id_rt         = rt;
        bus16.id_uses_rt    = uses_rt;
        bus16.id_is_mul     = is_mul;
        bus16.ex_mem_read   = mem_rd;
        bus16.ex_rt         = ert;
        bus16.ex_mispredict = mp;
        bus16.mul_done      = done;
        {pw, pr, iw, ifl, ih, ib, eb} = '0;
        if (!rst) begin
            m_age = 0;
            m_to = 1'b0;
            m_stalls = 0;
            ifl = 1'b1;
            ib = 1'b1;
        end
        e.ctl = {pw, pr, iw, ifl, ih, ib, eb, (m_age == 1), m_to};
        e.sc  = (m_stalls > 65535) ? 16'hffff : 16'(m_stalls);
        e.sc4 = (m_stalls > 15) ? 4'hf : 4'(m_stalls);
        if (rst) begin
            if (m_age > 0) begin
                by_done = done && (m_age > 1);
                fin = by_done || (m_age == TO);
                ih = !fin;
                eb = !fin;
                if (fin) begin
                    if (!by_done) m_to = 1'b1;
                    m_age = 0;
                end else begin
                    m_age++;
                end
            end else begin
                lu = mem_rd && (ert != 0) && vld && (ert == rs || (uses_rt && ert == rt));
                if (mp) begin
                    pw = 1'b1; pr = 1'b1; ifl = 1'b1; ib = 1'b1;
                end else if (lu) begin
                    ib = 1'b1;
                end else begin
                    pw = 1'b1; iw = 1'b1;
                    if (vld && is_mul) m_age = 1;
                end
            end
            if (!pw) m_stalls++;
            e.ctl[8:2] = {pw, pr, iw, ifl, ih, ib, eb};
        end
        e.cyc = cyc_no;
        cyc_no++;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int cyc, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] ctl;
            e = exp_q.pop_front();
            popped++;
            ctl = {bus16.pc_write, bus16.pc_redirect, bus16.ifid_write, bus16.ifid_flush,
                   bus16.idex_hold, bus16.idex_bubble, bus16.exmem_bubble,
                   bus16.mul_start, bus16.mul_timeout};
            chk("controls", e.cyc, 16'(ctl), 16'(e.ctl));
            chk("stall_count", e.cyc, bus16.stall_count, e.sc);
            chk("stall_count_w4", e.cyc, 16'(bus4.stall_count), 16'(e.sc4));
        end
    end

    initial begin
        // Reset, then idle.
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        // Load-use via rs, then ex_rt=0 (no stall), then via rt with/without uses_rt.
        step(1, 1, 8, 0, 0, 0, 1, 8, 0, 0);
        idle(1);
        step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 3, 8, 1, 0, 1, 8, 0, 0);
        step(1, 1, 3, 8, 0, 0, 1, 8, 0, 0);
        step(1, 0, 8, 0, 0, 0, 1, 8, 0, 0);
        // Mispredict overrides load-use and MULT issue.
        step(1, 1, 8, 0, 0, 1, 1, 8, 1, 0);
        idle(2);
        // MULT, done in the 33rd busy cycle.
        step(1, 1, 1, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 33; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, (i == 33));
        idle(3);
        // Minimum residency: done in first busy cycle is ignored.
        step(1, 1, 1, 2, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // MULT that never completes: timeout, sticky flag.
        step(1, 1, 1, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        // Reset in the 5th busy cycle.
        step(1, 1, 1, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Random traffic with small register indices to provoke collisions.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 499) != 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0));
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", cyc_no, 16'(popped), 16'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
